rps_move_capture: RTL and testbench
===================================

Name: rps_move_capture

Overview:
- Front-end stage that feeds the round-scoring block.
- Synchronizes and debounces each player's lock button, and checks each player's rock/paper/scissors switches for a legal one-hot selection.
- Keeps each player's move hidden until both players have locked in.
- Then presents both moves together with a one-cycle round_strobe, so the scoring stage evaluates exactly one round per strobe.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles required before a lock-button level is accepted (bench uses 4).
- HOLD_CYCLES, 24'd5000000: cycles the revealed moves stay presented after the strobe (bench uses 8).

Ports:
- clk input 1: system clock.
- rst input 1: reset, asynchronous, active-low.
- sw1 input 3: player 1 switches {rock, paper, scissors}; asynchronous.
- sw2 input 3: player 2 switches {rock, paper, scissors}; asynchronous.
- lock1_btn input 1: player 1 lock button, active-high, bouncy.
- lock2_btn input 1: player 2 lock button, active-high, bouncy.
- move1 output 3: player 1 move, one-hot {rock, paper, scissors}; 3'b000 when hidden.
- move2 output 3: player 2 move, same encoding as move1.
- round_strobe output 1: one-cycle pulse; move1 and move2 are valid in that cycle.
- locked1 output 1: player 1 has committed a move this round.
- locked2 output 1: player 2 has committed a move this round.
- err1 output 1: sticky flag; player 1's last lock attempt was illegal.
- err2 output 1: sticky flag; player 2's last lock attempt was illegal.
- state output 2: 00 COLLECT, 01 REVEAL, 10 HOLD.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: move1, move2, round_strobe, locked1, locked2, err1, err2 all 0; state = COLLECT.
  - Internal: synchronizers, debounce counters, hold counter and stored moves cleared.
  - Takes effect mid-round and mid-HOLD with no strobe emitted.
- Synchronization: every asynchronous input (sw1, sw2, lock1_btn, lock2_btn) passes through a 2-FF synchronizer. Switches are synchronized only, not debounced.
- Debounce, per button:
  - A 16-bit counter counts while the synchronized level differs from the stable level, and resets to 0 whenever the two match.
  - When the count reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized level and the counter clears.
  - A lock event is a 0->1 transition of the stable level: one cycle wide, one per physical press.
- COLLECT state:
  - Lock event with the synchronized switches exactly one-hot and lockN=0:
    - Store the switches as moveN; set lockedN=1; clear errN.
  - Lock event with switches 000 or more than one bit set, and lockN=0:
    - Set errN=1; store nothing; lockedN stays 0.
  - Lock event while lockedN=1: ignored. The move cannot be changed and errN is unaffected.
  - Switch changes after a lock have no effect.
  - move1/move2 outputs stay 000 while in COLLECT, even when locked.
  - Both players may lock in the same cycle; each lock is evaluated independently.
  - Once locked1 & locked2 are both 1 (registered values), transition to REVEAL on the next edge.
- REVEAL state (exactly 1 cycle):
  - round_strobe=1; move1/move2 drive the stored moves.
  - Hold counter loads 0; next state is HOLD.
- HOLD state:
  - move1/move2 are held and round_strobe=0.
  - Lock events are ignored and do not set err.
  - The counter increments each cycle; at HOLD_CYCLES-1, next state is COLLECT.
  - On the COLLECT entry edge: locked1, locked2, move1, move2 and stored moves clear to 0. err1/err2 persist.
- Latency:
  - Stable lock level follows the synchronized button level after DEBOUNCE_CYCLES cycles; the synchronizer adds 2 cycles before that.
  - lockedN rises 1 cycle after the lock event.
  - round_strobe is asserted 1 cycle after the second locked flag rises.
- Presses in progress across a state change are tracked normally. A press whose stable rise lands in HOLD is consumed and lost; the player must release and press again.
- Invariants:
  - round_strobe is never asserted on two consecutive cycles.
  - Exactly one strobe per round.
  - move1/move2 are always 000 or one-hot.

Test Plan:
- Reset: drive rst=0 mid-HOLD with moves presented -> all outputs 0 and state=00 immediately; after release, no round_strobe until two new locks.
- Basic round: sw1=100, press lock1; sw2=001, press lock2; clean presses -> locked1 then locked2 rise; move1/move2 read 000 until REVEAL; then one cycle with round_strobe=1, move1=100, move2=001; values held 8 cycles; then return to COLLECT with all cleared.
- Bounce: lock1_btn toggles 3 times at 1-cycle spacing, then stays high 10 cycles (DEBOUNCE_CYCLES=4) -> exactly one lock event; locked1=1 once.
- Illegal selection: sw1=110, press lock1 -> err1=1, locked1=0; then sw1=010, press lock1 -> err1=0, locked1=1, later move1=010.
- Simultaneous and relock: both players lock in the same cycle with 010/010 -> a single strobe; a relock by player 1 with sw1=100 before player 2 locks (separate run) leaves move1 at its first value.
- HOLD lockout: press lock2 during HOLD -> no lock and no err; after return to COLLECT, locked2 remains 0 until a fresh press.

Source files
------------

// File: rtl/rps_move_capture.sv
// Rock/paper/scissors move capture: synchronizes and debounces the lock buttons, validates
// one-hot selections, and reveals both moves together with a one-cycle round strobe.
module rps_move_capture #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] HOLD_CYCLES     = 24'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw1,
  input  logic [2:0] sw2,
  input  logic       lock1_btn,
  input  logic       lock2_btn,
  output logic [2:0] move1,
  output logic [2:0] move2,
  output logic       round_strobe,
  output logic       locked1,
  output logic       locked2,
  output logic       err1,
  output logic       err2,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_REVEAL  = 2'b01,
    ST_HOLD    = 2'b10
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0][2:0]  r_sw_s1, r_sw_s2;
  logic [1:0]       r_btn_s1, r_btn_s2;
  logic [1:0]       r_stable, r_stable_d;
  logic [1:0][15:0] r_db_cnt;
  logic [1:0]       r_locked, r_err;
  logic [1:0][2:0]  r_move;
  logic [23:0]      r_hold_cnt;

  logic [1:0] w_lock_ev;
  logic [1:0] w_onehot;
  logic       w_hold_done;
  logic       w_show;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_db_cnt   <= '0;
    end else begin
      r_sw_s1    <= {sw2, sw1};
      r_sw_s2    <= r_sw_s1;
      r_btn_s1   <= {lock2_btn, lock1_btn};
      r_btn_s2   <= r_btn_s1;
      r_stable_d <= r_stable;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_btn_s2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
            r_stable[i] <= r_btn_s2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_lock_ev   = r_stable & ~r_stable_d;
  assign w_hold_done = (r_hold_cnt == HOLD_CYCLES - 24'd1);

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_onehot[i] = (r_sw_s2[i] == 3'b100) || (r_sw_s2[i] == 3'b010) || (r_sw_s2[i] == 3'b001);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_COLLECT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (&r_locked) w_state_nxt = ST_REVEAL;
      ST_REVEAL:  w_state_nxt = ST_HOLD;
      ST_HOLD:    if (w_hold_done) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // Lock evaluation happens only in COLLECT, so presses whose stable rise lands in HOLD are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked   <= '0;
      r_err      <= '0;
      r_move     <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          for (int unsigned i = 0; i < 2; i++) begin
            if (w_lock_ev[i] && !r_locked[i]) begin
              if (w_onehot[i]) begin
                r_move[i]   <= r_sw_s2[i];
                r_locked[i] <= 1'b1;
                r_err[i]    <= 1'b0;
              end else begin
                r_err[i]    <= 1'b1;
              end
            end
          end
        end
        ST_REVEAL: r_hold_cnt <= '0;
        ST_HOLD: begin
          r_hold_cnt <= r_hold_cnt + 24'd1;
          if (w_hold_done) begin
            r_locked <= '0;
            r_move   <= '0;
          end
        end
        default: r_hold_cnt <= '0;
      endcase
    end
  end

  assign w_show       = (r_state != ST_COLLECT);
  assign move1        = w_show ? r_move[0] : 3'b000;
  assign move2        = w_show ? r_move[1] : 3'b000;
  assign round_strobe = (r_state == ST_REVEAL);
  assign locked1      = r_locked[0];
  assign locked2      = r_locked[1];
  assign err1         = r_err[0];
  assign err2         = r_err[1];
  assign state        = r_state;

endmodule

// File: tb/tb_rps_move_capture.sv
// Scoreboard bench for rps_move_capture: expected move pairs are queued when a round is
// completed by stimulus and compared when round_strobe fires.
`timescale 1ns/1ps
module tb_rps_move_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw1 = '0, sw2 = '0;
  logic       lock1_btn = 1'b0, lock2_btn = 1'b0;
  logic [2:0] move1, move2;
  logic       round_strobe, locked1, locked2, err1, err2;
  logic [1:0] state;

  rps_move_capture #(
    .DEBOUNCE_CYCLES(16'd4),
    .HOLD_CYCLES(24'd8)
  ) dut (
    .clk(clk), .rst(rst), .sw1(sw1), .sw2(sw2),
    .lock1_btn(lock1_btn), .lock2_btn(lock2_btn),
    .move1(move1), .move2(move2), .round_strobe(round_strobe),
    .locked1(locked1), .locked2(locked2), .err1(err1), .err2(err2),
    .state(state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err = 0;
  int         n_strobe = 0;
  int         n_l1_rise = 0;
  int         n0;
  logic [5:0] sb[$];
  logic [5:0] e;
  logic       prev_strobe = 1'b0, prev_l1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int p);
    if (p == 1) lock1_btn = 1'b1; else lock2_btn = 1'b1;
    tick(9);
    if (p == 1) lock1_btn = 1'b0; else lock2_btn = 1'b0;
    tick(8);
  endtask

  task automatic wait_strobe();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (round_strobe) seen = 1'b1;
    end
    chk("strobe_timeout", seen, 1);
  endtask

  task automatic check_hold(input logic [2:0] m1, input logic [2:0] m2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_state", state, 2'b10);
      chk("hold_move1", move1, m1);
      chk("hold_move2", move2, m2);
    end
    @(negedge clk);
    chk("ret_state", state, 2'b00);
    chk("ret_move1", move1, 0);
    chk("ret_move2", move2, 0);
    chk("ret_locked1", locked1, 0);
    chk("ret_locked2", locked2, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_strobe <= 1'b0;
      prev_l1     <= 1'b0;
    end else begin
      if (round_strobe) begin
        chk("strobe_consec", prev_strobe, 0);
        if (sb.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("strobe_move1", move1, e[5:3]);
          chk("strobe_move2", move2, e[2:0]);
        end
        n_strobe <= n_strobe + 1;
      end
      if (locked1 && !prev_l1) n_l1_rise <= n_l1_rise + 1;
      prev_strobe <= round_strobe;
      prev_l1     <= locked1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_move1", move1, 0);
    chk("rst_move2", move2, 0);
    chk("rst_strobe", round_strobe, 0);
    chk("rst_locked", {locked1, locked2}, 0);
    chk("rst_err", {err1, err2}, 0);
    rst = 1'b1;
    tick(3);

    // basic round
    sw1 = 3'b100; sw2 = 3'b001;
    press(1);
    chk("basic_locked1", locked1, 1);
    chk("basic_locked2", locked2, 0);
    chk("basic_hidden1", move1, 0);
    chk("basic_state", state, 0);
    sb.push_back({3'b100, 3'b001});
    lock2_btn = 1'b1;
    wait_strobe();
    check_hold(3'b100, 3'b001);
    lock2_btn = 1'b0;
    tick(8);

    // bouncy press
    sw1 = 3'b010;
    n0 = n_l1_rise;
    lock1_btn = 1'b1; tick(1); lock1_btn = 1'b0; tick(1);
    lock1_btn = 1'b1; tick(1); lock1_btn = 1'b0; tick(1);
    lock1_btn = 1'b1; tick(10);
    lock1_btn = 1'b0; tick(8);
    chk("bounce_locked1", locked1, 1);
    chk("bounce_rises", n_l1_rise - n0, 1);
    sw2 = 3'b100;
    sb.push_back({3'b010, 3'b100});
    lock2_btn = 1'b1;
    wait_strobe();
    check_hold(3'b010, 3'b100);
    lock2_btn = 1'b0;
    tick(8);

    // illegal then legal selection
    sw1 = 3'b110;
    press(1);
    chk("illegal_err1", err1, 1);
    chk("illegal_locked1", locked1, 0);
    sw1 = 3'b010;
    press(1);
    chk("legal_err1", err1, 0);
    chk("legal_locked1", locked1, 1);
    sw2 = 3'b001;
    sb.push_back({3'b010, 3'b001});
    lock2_btn = 1'b1;
    wait_strobe();
    check_hold(3'b010, 3'b001);
    lock2_btn = 1'b0;
    tick(8);

    // simultaneous lock
    sw1 = 3'b010; sw2 = 3'b010;
    sb.push_back({3'b010, 3'b010});
    n0 = n_strobe;
    lock1_btn = 1'b1; lock2_btn = 1'b1;
    wait_strobe();
    check_hold(3'b010, 3'b010);
    lock1_btn = 1'b0; lock2_btn = 1'b0;
    tick(10);
    chk("simul_strobes", n_strobe - n0, 1);

    // relock is ignored
    sw1 = 3'b001;
    press(1);
    sw1 = 3'b100;
    press(1);
    chk("relock_locked1", locked1, 1);
    chk("relock_err1", err1, 0);
    sw2 = 3'b010;
    sb.push_back({3'b001, 3'b010});
    lock2_btn = 1'b1;
    wait_strobe();
    check_hold(3'b001, 3'b010);
    lock2_btn = 1'b0;
    tick(8);

    // press during HOLD is lost
    sw2 = 3'b100;
    press(2);
    sw1 = 3'b001;
    sb.push_back({3'b001, 3'b100});
    lock1_btn = 1'b1;
    wait_strobe();
    lock2_btn = 1'b1;
    check_hold(3'b001, 3'b100);
    chk("holdlock_err2", err2, 0);
    lock1_btn = 1'b0; lock2_btn = 1'b0;
    tick(10);
    chk("holdlock_locked2", locked2, 0);
    chk("holdlock_err2b", err2, 0);
    sw2 = 3'b010;
    press(2);
    chk("fresh_locked2", locked2, 1);

    // asynchronous reset mid-HOLD
    sw1 = 3'b100;
    sb.push_back({3'b100, 3'b010});
    lock1_btn = 1'b1;
    wait_strobe();
    tick(3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_move1", move1, 0);
    chk("midrst_move2", move2, 0);
    chk("midrst_strobe", round_strobe, 0);
    chk("midrst_locked", {locked1, locked2}, 0);
    lock1_btn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n0 = n_strobe;
    tick(20);
    chk("postrst_strobes", n_strobe - n0, 0);
    chk("postrst_locked", {locked1, locked2}, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
